// File: rtl/tiny16_if.sv
// tiny16 control-side bus: memory port plus register-file port.
//   master : the sequencer (drives selects, strobes, memory requests, status)
//   slave  : memory + register file side (returns read data, ready, src/dst)
interface tiny16_if;
   logic [15:0] mem_addr;
   logic        mem_rd;
   logic        mem_wr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_ready;
   logic [2:0]  src_sel;
   logic [2:0]  dst_sel;
   logic [15:0] src;
   logic [15:0] dst;
   logic        in_en;
   logic [15:0] wb_data;
   logic        pc_inc;
   logic [1:0]  flags;
   logic        halted;

   modport master (
      output mem_addr, mem_rd, mem_wr, mem_wdata,
      output src_sel, dst_sel, in_en, wb_data, pc_inc, flags, halted,
      input  mem_rdata, mem_ready, src, dst
   );

   modport slave (
      input  mem_addr, mem_rd, mem_wr, mem_wdata,
      input  src_sel, dst_sel, in_en, wb_data, pc_inc, flags, halted,
      output mem_rdata, mem_ready, src, dst
   );
endinterface

// File: rtl/tiny16_control.sv
// tiny16 fetch/decode/execute sequencer.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset; also gates every output strobe
//   bus : tiny16_if.master -- memory request port (mem_*), register-file
//         selects/strobes (src_sel, dst_sel, in_en, wb_data, pc_inc),
//         status (flags = {C,Z}, halted)
//
// state   | meaning
// FETCH   | read instruction at r0; on ready latch ir and bump r0
// EXEC    | decode ir; ALU/LDI/jump write-back happens in this cycle
// MEM     | LD or ST data transfer, waits for mem_ready
// HALT    | idle with halted=1 until reset
module tiny16_control (
   input  logic     clk,
   input  logic     rst,
   tiny16_if.master bus
);

   typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

   state_t      state, state_nxt;
   logic [15:0] ir, ir_nxt;
   logic        c_flag, z_flag, c_nxt, z_nxt;

   logic [3:0]  op;
   logic [2:0]  fd, fs;
   logic [8:0]  imm9;

   logic [15:0] addr_c, wdata_c, wb_c, alu_res;
   logic        rd_c, wr_c, in_en_c, pc_inc_c, halted_c, alu_wr;
   logic [16:0] sum;

   assign op   = ir[15:12];
   assign fd   = ir[11:9];
   assign fs   = ir[8:6];
   assign imm9 = ir[8:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= S_FETCH;
         ir     <= '0;
         c_flag <= 1'b0;
         z_flag <= 1'b0;
      end else begin
         state  <= state_nxt;
         ir     <= ir_nxt;
         c_flag <= c_nxt;
         z_flag <= z_nxt;
      end
   end

   // Selects depend only on state/ir so the combinational src/dst return
   // path from the register file never loops back into them.
   always_comb begin
      bus.src_sel = 3'd0;
      bus.dst_sel = 3'd0;
      case (state)
         S_EXEC: begin
            bus.src_sel = fs;
            bus.dst_sel = (op == 4'hB || op == 4'hC || op == 4'hD) ? 3'd0 : fd;
         end
         S_MEM: begin
            bus.src_sel = fs;
            bus.dst_sel = fd;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_nxt = state;
      ir_nxt    = ir;
      c_nxt     = c_flag;
      z_nxt     = z_flag;
      addr_c    = '0;
      wdata_c   = '0;
      wb_c      = '0;
      rd_c      = 1'b0;
      wr_c      = 1'b0;
      in_en_c   = 1'b0;
      pc_inc_c  = 1'b0;
      halted_c  = 1'b0;
      alu_wr    = 1'b0;
      alu_res   = '0;
      sum       = '0;

      case (state)
         S_FETCH: begin
            addr_c = bus.src;
            rd_c   = 1'b1;
            if (bus.mem_ready) begin
               ir_nxt    = bus.mem_rdata;
               pc_inc_c  = 1'b1;
               state_nxt = S_EXEC;
            end
         end

         S_EXEC: begin
            state_nxt = S_FETCH;
            case (op)
               4'h1: begin in_en_c = 1'b1; wb_c = bus.src; end
               4'h2: begin
                  sum     = {1'b0, bus.dst} + {1'b0, bus.src};
                  alu_res = sum[15:0];
                  c_nxt   = sum[16];
                  alu_wr  = 1'b1;
               end
               4'h3: begin
                  // bit 16 of the widened difference is the borrow (d < s)
                  sum     = {1'b0, bus.dst} - {1'b0, bus.src};
                  alu_res = sum[15:0];
                  c_nxt   = sum[16];
                  alu_wr  = 1'b1;
               end
               4'h4: begin alu_res = bus.dst & bus.src; c_nxt = 1'b0; alu_wr = 1'b1; end
               4'h5: begin alu_res = bus.dst | bus.src; c_nxt = 1'b0; alu_wr = 1'b1; end
               4'h6: begin alu_res = bus.dst ^ bus.src; c_nxt = 1'b0; alu_wr = 1'b1; end
               4'h7: begin alu_res = bus.src >> 1; c_nxt = bus.src[0]; alu_wr = 1'b1; end
               4'h8: begin in_en_c = 1'b1; wb_c = {7'b0, imm9}; end
               4'h9, 4'hA: state_nxt = S_MEM;
               4'hB: begin in_en_c = 1'b1;   wb_c = bus.src; end
               4'hC: begin in_en_c = z_flag; wb_c = bus.src; end
               4'hD: begin in_en_c = c_flag; wb_c = bus.src; end
               4'hF: state_nxt = S_HALT;
               default: ;
            endcase
            if (alu_wr) begin
               in_en_c = 1'b1;
               wb_c    = alu_res;
               z_nxt   = (alu_res == 16'h0000);
            end
         end

         S_MEM: begin
            if (op == 4'h9) begin
               addr_c = bus.src;
               rd_c   = 1'b1;
               if (bus.mem_ready) begin
                  in_en_c = 1'b1;
                  wb_c    = bus.mem_rdata;
               end
            end else begin
               addr_c  = bus.dst;
               wdata_c = bus.src;
               wr_c    = 1'b1;
            end
            if (bus.mem_ready) state_nxt = S_FETCH;
         end

         S_HALT: halted_c = 1'b1;

         default: state_nxt = S_FETCH;
      endcase
   end

   // Reset kills every strobe and bus value immediately, independent of the
   // clock, so an interrupted transfer never completes.
   assign bus.mem_addr  = rst ? addr_c  : '0;
   assign bus.mem_wdata = rst ? wdata_c : '0;
   assign bus.wb_data   = rst ? wb_c    : '0;
   assign bus.mem_rd    = rst & rd_c;
   assign bus.mem_wr    = rst & wr_c;
   assign bus.in_en     = rst & in_en_c;
   assign bus.pc_inc    = rst & pc_inc_c;
   assign bus.halted    = rst & halted_c;
   assign bus.flags     = {c_flag, z_flag};

endmodule

// File: tb/tb_tiny16_control.sv
// Testbench for tiny16_control: behavioural memory and register file around
// the sequencer, plus an instruction-level reference model of the tiny16 ISA.
module tb_tiny16_control;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   tiny16_if bus();

   tiny16_control dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [15:0] mem [65536];
   logic [15:0] gpr [8];

   assign bus.mem_rdata = mem[bus.mem_addr];
   assign bus.src       = gpr[bus.src_sel];
   assign bus.dst       = gpr[bus.dst_sel];

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 8; i++) gpr[i] <= '0;
      end else begin
         if (bus.in_en)  gpr[bus.dst_sel] <= bus.wb_data;
         if (bus.pc_inc) gpr[0] <= gpr[0] + 16'd1;
      end
   end

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // instruction-level reference state
   logic [15:0] mm [65536];
   logic [15:0] ref_gpr [8];
   logic        ref_c, ref_z, ref_halted;
   int          ref_count, base, cyc, waits;
   bit          mon_en, first, pend, rand_ready;
   logic [33:0] pend_val;

   task automatic model_step();
      logic [15:0] w, r;
      logic [16:0] t;
      logic [2:0]  d, s;
      w = mm[ref_gpr[0]];
      ref_gpr[0] = ref_gpr[0] + 16'd1;
      d = w[11:9];
      s = w[8:6];
      r = '0;
      base = (w[15:12] == 4'h9 || w[15:12] == 4'hA) ? 3 : 2;
      ref_count++;
      case (w[15:12])
         4'h1: ref_gpr[d] = ref_gpr[s];
         4'h2: begin t = {1'b0, ref_gpr[d]} + {1'b0, ref_gpr[s]}; r = t[15:0]; ref_c = t[16]; end
         4'h3: begin r = ref_gpr[d] - ref_gpr[s]; ref_c = (ref_gpr[d] < ref_gpr[s]); end
         4'h4: begin r = ref_gpr[d] & ref_gpr[s]; ref_c = 1'b0; end
         4'h5: begin r = ref_gpr[d] | ref_gpr[s]; ref_c = 1'b0; end
         4'h6: begin r = ref_gpr[d] ^ ref_gpr[s]; ref_c = 1'b0; end
         4'h7: begin r = ref_gpr[s] / 16'd2; ref_c = ref_gpr[s][0]; end
         4'h8: ref_gpr[d] = {7'b0, w[8:0]};
         4'h9: ref_gpr[d] = mm[ref_gpr[s]];
         4'hA: mm[ref_gpr[d]] = ref_gpr[s];
         4'hB: ref_gpr[0] = ref_gpr[s];
         4'hC: if (ref_z) ref_gpr[0] = ref_gpr[s];
         4'hD: if (ref_c) ref_gpr[0] = ref_gpr[s];
         4'hF: ref_halted = 1'b1;
         default: ;
      endcase
      if (w[15:12] >= 4'h2 && w[15:12] <= 4'h7) begin
         ref_gpr[d] = r;
         ref_z = (r == 16'h0000);
      end
   endtask

   task automatic start_model();
      for (int i = 0; i < 65536; i++) mm[i] = mem[i];
      for (int i = 0; i < 8; i++) ref_gpr[i] = '0;
      ref_c = 1'b0; ref_z = 1'b0; ref_halted = 1'b0;
      ref_count = 0; cyc = 0; waits = 0; base = 2;
      first = 1'b1; pend = 1'b0; mon_en = 1'b1;
   endtask

   task automatic monitor();
      cyc++;
      if ((bus.mem_rd || bus.mem_wr) && !bus.mem_ready) waits++;
      check_eq("excl", 64'({bus.in_en & bus.pc_inc, bus.mem_rd & bus.mem_wr}), 64'(0));
      if (pend)
         check_eq("hold", 64'({bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_wdata}), 64'(pend_val));
      pend     = (bus.mem_rd || bus.mem_wr) && !bus.mem_ready;
      pend_val = {bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_wdata};
      if (bus.pc_inc) begin
         check_eq("fetch_after_hlt", 64'(ref_halted), 64'(0));
         check_eq("fetch_addr", 64'(bus.mem_addr), 64'(ref_gpr[0]));
         check_eq("fetch_word", 64'(bus.mem_rdata), 64'(mm[ref_gpr[0]]));
         for (int i = 0; i < 8; i++)
            check_eq($sformatf("gpr%0d", i), 64'(gpr[i]), 64'(ref_gpr[i]));
         check_eq("flags", 64'(bus.flags), 64'({ref_c, ref_z}));
         if (!first) check_eq("latency", 64'(cyc), 64'(base + waits));
         first = 1'b0;
         cyc   = 0;
         waits = 0;
         model_step();
      end
   endtask

   task automatic sample();
      @(negedge clk);
      if (mon_en) monitor();
      if (rst && bus.mem_wr && bus.mem_ready) mem[bus.mem_addr] = bus.mem_wdata;
   endtask

   task automatic drive();
      @(posedge clk);
      #1;
      if (rand_ready) bus.mem_ready = ($urandom_range(0, 2) != 0);
   endtask

   task automatic enter_reset();
      drive();
      rst    = 1'b0;
      mon_en = 1'b0;
      for (int i = 0; i < 65536; i++) mem[i] = '0;
   endtask

   task automatic run_prog(input int max_instr, input int budget);
      bit done;
      done = 1'b0;
      for (int k = 0; k < budget && !done; k++) begin
         sample();
         done = (ref_halted && bus.halted) || (ref_count >= max_instr);
         drive();
      end
      check_eq("prog_done", 64'(done), 64'(1));
   endtask

   logic [15:0] prog2 [5]  = '{16'h8820, 16'h9500, 16'h8601, 16'h24C0, 16'hC100};
   logic [15:0] prog3 [11] = '{16'h8C41, 16'h9F80, 16'h8C40, 16'hADC0, 16'h8201, 16'h8402,
                               16'h3280, 16'h8809, 16'hD100, 16'hC100, 16'hF000};

   initial begin
      rst = 1'b0;
      bus.mem_ready = 1'b1;
      rand_ready = 1'b0;
      mon_en = 1'b0;
      for (int i = 0; i < 65536; i++) mem[i] = '0;
      mem[0] = 16'h8A20;
      #3;
      check_eq("rst_strobes", 64'({bus.mem_rd, bus.mem_wr, bus.in_en, bus.pc_inc, bus.halted}), 64'(0));
      check_eq("rst_bus", 64'({bus.mem_addr, bus.mem_wdata, bus.wb_data}), 64'(0));
      check_eq("rst_flags", 64'(bus.flags), 64'(0));

      // LDI r5,0x020 with zero-wait memory
      start_model();
      @(posedge clk); #1 rst = 1'b1;
      sample();
      check_eq("c0_fetch", 64'({bus.mem_rd, bus.pc_inc, bus.in_en, bus.mem_addr}), 64'({3'b110, 16'h0000}));
      drive();
      sample();
      check_eq("c1_exec", 64'({bus.in_en, bus.pc_inc, bus.dst_sel, bus.wb_data}), 64'({2'b10, 3'd5, 16'h0020}));
      drive();
      sample();
      check_eq("c2_fetch", 64'({bus.mem_rd, bus.mem_addr}), 64'({1'b1, 16'h0001}));
      drive();

      // LD / ADD overflow / taken JZ, random wait states
      enter_reset();
      for (int i = 0; i < 5; i++) mem[i] = prog2[i];
      mem[16'h0020] = 16'hFFFF;
      rand_ready = 1'b1;
      start_model();
      drive(); rst = 1'b1;
      run_prog(100, 2000);
      check_eq("p2_r2", 64'(gpr[2]), 64'(16'h0000));
      check_eq("p2_flags", 64'(bus.flags), 64'(2'b11));
      check_eq("p2_r0", 64'(gpr[0]), 64'(16'h0021));

      // ST, SUB borrow, JC taken, JZ not taken, HLT
      enter_reset();
      for (int i = 0; i < 11; i++) mem[i] = prog3[i];
      mem[16'h0041] = 16'hBEEF;
      start_model();
      drive(); rst = 1'b1;
      run_prog(100, 2000);
      check_eq("p3_store", 64'(mem[16'h0040]), 64'(16'hBEEF));
      check_eq("p3_r1", 64'(gpr[1]), 64'(16'hFFFF));
      check_eq("p3_flags", 64'(bus.flags), 64'(2'b10));
      check_eq("p3_r0", 64'(gpr[0]), 64'(16'd11));
      for (int i = 0; i < 20; i++) begin
         sample();
         check_eq("halt_idle", 64'({bus.mem_rd, bus.mem_wr, bus.in_en, bus.pc_inc, bus.halted}), 64'(5'b00001));
         drive();
      end

      // reset in the middle of a stalled fetch
      enter_reset();
      rand_ready = 1'b0;
      bus.mem_ready = 1'b0;
      drive(); rst = 1'b1;
      sample();
      check_eq("mf_req", 64'({bus.mem_rd, bus.halted, bus.mem_addr}), 64'({2'b10, 16'h0000}));
      drive();
      sample();
      rst = 1'b0;
      #1;
      check_eq("mf_drop", 64'({bus.mem_rd, bus.mem_wr, bus.in_en, bus.pc_inc, bus.halted}), 64'(0));
      check_eq("mf_addr", 64'(bus.mem_addr), 64'(0));
      drive();
      bus.mem_ready = 1'b1;
      rst = 1'b1;
      sample();
      check_eq("mf_restart", 64'({bus.mem_rd, bus.pc_inc, bus.mem_addr}), 64'({2'b11, 16'h0000}));
      drive();

      // random programs over the whole address space
      for (int p = 0; p < 4; p++) begin
         logic [15:0] w;
         enter_reset();
         for (int i = 0; i < 65536; i++) begin
            w = 16'($urandom());
            if (w[15:12] == 4'hF && $urandom_range(0, 31) != 0) w[15:12] = 4'($urandom_range(0, 14));
            mem[i] = w;
         end
         rand_ready = 1'b1;
         start_model();
         drive(); rst = 1'b1;
         run_prog(300, 4000);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
